// File: rtl/spi_regctl_pkg.sv
// Shared types for the SPI register controller: FSM states, response status codes and
// frame field offsets derived from the address/data widths.
package spi_regctl_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StReq      = 2'd1,
        StComplete = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        StatusOk         = 2'b00,
        StatusBusError   = 2'b01,
        StatusFrameError = 2'b10,
        StatusOverrun    = 2'b11
    } status_e;

    function automatic int unsigned frame_width(int unsigned aw, int unsigned dw);
        return 2 + aw + dw;
    endfunction

    function automatic int unsigned wr_bit(int unsigned aw, int unsigned dw);
        return frame_width(aw, dw) - 1;
    endfunction

    function automatic int unsigned rsv_bit(int unsigned aw, int unsigned dw);
        return frame_width(aw, dw) - 2;
    endfunction

endpackage

// File: rtl/spi_regctl_timeout.sv
// Loadable down-counter: reloaded while load is high, counts while enable is high and
// flags expire during the CYCLES-th enabled cycle.
module spi_regctl_timeout #(
    parameter int unsigned CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntWidth = $clog2(CYCLES + 1);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CntWidth'(CYCLES - 1);
        end else if (enable && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CntWidth'(CYCLES - 1);
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == '0);

endmodule

// File: rtl/spi_register_controller.sv
// Decodes SPI frames into register bus reads/writes and stages each result as the next MISO frame.
// Optional bus ack timeout is enabled by defining SPI_REGCTL_TIMEOUT_EN.
module spi_register_controller
    import spi_regctl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned FRAME_WIDTH   = 2 + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   system_clk,
    input  logic                   system_nreset,
    input  logic [FRAME_WIDTH-1:0] spi_value_mosi,
    input  logic                   spi_value_valid,
    input  logic                   spi_cs_stop,
    output logic [FRAME_WIDTH-1:0] spi_value_miso,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic [DATA_WIDTH-1:0]  bus_wdata,
    input  logic                   bus_ack,
    input  logic [DATA_WIDTH-1:0]  bus_rdata,
    output logic                   busy
);

    localparam int unsigned WrBit  = wr_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned RsvBit = rsv_bit(ADDR_WIDTH, DATA_WIDTH);

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [FRAME_WIDTH-1:0]  response_q, response_d;
    logic                    overrun_q, overrun_d;
    logic                    timer_expire;
    status_e                 done_status;

    assign done_status = overrun_q ? StatusOverrun : StatusOk;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        response_d = response_q;
        overrun_d  = overrun_q;
        // A frame arriving while a command is in flight is dropped but remembered
        if (spi_value_valid && state_q != StIdle) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (spi_value_valid) begin
                    if (!spi_value_mosi[RsvBit]) begin
                        we_d    = spi_value_mosi[WrBit];
                        addr_d  = spi_value_mosi[DATA_WIDTH +: ADDR_WIDTH];
                        wdata_d = spi_value_mosi[DATA_WIDTH-1:0];
                        state_d = StReq;
                    end else begin
                        response_d = {StatusFrameError, spi_value_mosi[FRAME_WIDTH-3:0]};
                    end
                end else if (spi_cs_stop) begin
                    response_d = {StatusFrameError, {(FRAME_WIDTH-2){1'b0}}};
                end
            end
            StReq: begin
                // Ack in the expiry cycle still counts as success
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = StComplete;
                end else if (timer_expire) begin
                    response_d = {StatusBusError, addr_q, {DATA_WIDTH{1'b0}}};
                    state_d    = StIdle;
                end
            end
            StComplete: begin
                response_d = {done_status, addr_q, we_q ? wdata_q : rdata_q};
                overrun_d  = spi_value_valid;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge system_clk or negedge system_nreset) begin
        if (!system_nreset) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            response_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            response_q <= response_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef SPI_REGCTL_TIMEOUT_EN
    spi_regctl_timeout #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (system_clk),
        .rst_n (system_nreset),
        .load  (state_q != StReq),
        .enable(state_q == StReq),
        .expire(timer_expire)
    );
`else
    assign timer_expire = 1'b0;
`endif

    assign bus_req   = (state_q == StReq);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

    assign spi_value_miso = busy ? {StatusOverrun, addr_q, {DATA_WIDTH{1'b0}}} : response_q;

endmodule
